pipeline_hazard_ctrl: RTL and testbench

//   Central stall/flush sequencer for the 5-stage pipelined-plus-cache core. Combines decode

---
 rtl/pipeline_hazard_ctrl.sv | 121 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage core.
// Merges load-use, branch and cache-miss hazards.
module pipeline_hazard_ctrl #(
  parameter int CNT_WIDTH    = 32,
  parameter int MISS_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_use_d,
  input  logic                 branch_taken_e,
  input  logic                 icache_stall_f,
  input  logic                 dcache_req_m,
  input  logic                 dcache_hit_m,
  input  logic                 dcache_ready,
  output logic                 pc_en,
  output logic                 en_d,
  output logic                 en_e,
  output logic                 en_m,
  output logic                 en_w,
  output logic                 flush_n_d,
  output logic                 flush_n_e,
  output logic                 redirect_f,
  output logic                 miss_busy,
  output logic                 miss_err,
  output logic [CNT_WIDTH-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    MISS,
    REPLAY
  } state_t;

  localparam logic [8:0] TO = 9'(MISS_TIMEOUT);

  state_t     state;
  state_t     state_n;
  logic [7:0] timer;
  logic       detect;
  logic       dmiss;

  assign detect = (state == IDLE)
                & dcache_req_m
                & ~dcache_hit_m;
  assign dmiss  = detect | (state != IDLE);

  assign miss_busy = ~rst & (state != IDLE);

  // Miss FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Miss FSM next-state: ready is only honoured once in MISS
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (detect) state_n = MISS;
      MISS:    if (dcache_ready) state_n = REPLAY;
      REPLAY:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Miss timer and sticky timeout flag
  always_ff @(posedge clk) begin
    if (rst) begin
      timer    <= '0;
      miss_err <= 1'b0;
    end else if (state == MISS && !dcache_ready) begin
      if (timer != 8'hFF) timer <= timer + 8'd1;
      if (({1'b0, timer} + 9'd1) == TO)
        miss_err <= 1'b1;
    end else begin
      timer <= '0;
    end
  end

  // Hazard priority: D-miss, branch, load-use, I-miss
  always_comb begin
    pc_en      = 1'b1;
    en_d       = 1'b1;
    en_e       = 1'b1;
    en_m       = 1'b1;
    en_w       = 1'b1;
    flush_n_d  = 1'b1;
    flush_n_e  = 1'b1;
    redirect_f = 1'b0;
    if (rst) begin
      pc_en     = 1'b0;
      flush_n_d = 1'b0;
      flush_n_e = 1'b0;
    end else if (dmiss) begin
      pc_en = 1'b0;
      en_d  = 1'b0;
      en_e  = 1'b0;
      en_m  = 1'b0;
    end else if (branch_taken_e) begin
      redirect_f = 1'b1;
      flush_n_d  = 1'b0;
      flush_n_e  = 1'b0;
    end else if (load_use_d) begin
      pc_en = 1'b0;
      en_d  = 1'b0;
      en_e  = 1'b0;
    end else if (icache_stall_f) begin
      pc_en = 1'b0;
      en_d  = 1'b0;
    end
  end

  // Saturating count of cycles with the PC held
  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (!pc_en && stall_cnt != '1)
      stall_cnt <= stall_cnt + CNT_WIDTH'(1);
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl.
// Small counter width exposes saturation.
module tb_pipeline_hazard_ctrl;

  localparam int CW = 4;

  // {pc_en,en_d,en_e,en_m,en_w,fl_d,fl_e,redir,busy}
  localparam logic [8:0] C_RST = 9'b011110000;
  localparam logic [8:0] C_DEF = 9'b111111100;
  localparam logic [8:0] C_LU  = 9'b000111100;
  localparam logic [8:0] C_BR  = 9'b111110010;
  localparam logic [8:0] C_IM  = 9'b001111100;
  localparam logic [8:0] C_DMI = 9'b000011100;
  localparam logic [8:0] C_DMB = 9'b000011101;

  logic          clk;
  logic          rst;
  logic          load_use_d;
  logic          branch_taken_e;
  logic          icache_stall_f;
  logic          dcache_req_m;
  logic          dcache_hit_m;
  logic          dcache_ready;
  logic          pc_en;
  logic          en_d;
  logic          en_e;
  logic          en_m;
  logic          en_w;
  logic          flush_n_d;
  logic          flush_n_e;
  logic          redirect_f;
  logic          miss_busy;
  logic          miss_err;
  logic [CW-1:0] stall_cnt;
  logic [8:0]    ctl;

  int total;
  int passed;

  pipeline_hazard_ctrl #(
    .CNT_WIDTH    (CW),
    .MISS_TIMEOUT (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .load_use_d     (load_use_d),
    .branch_taken_e (branch_taken_e),
    .icache_stall_f (icache_stall_f),
    .dcache_req_m   (dcache_req_m),
    .dcache_hit_m   (dcache_hit_m),
    .dcache_ready   (dcache_ready),
    .pc_en          (pc_en),
    .en_d           (en_d),
    .en_e           (en_e),
    .en_m           (en_m),
    .en_w           (en_w),
    .flush_n_d      (flush_n_d),
    .flush_n_e      (flush_n_e),
    .redirect_f     (redirect_f),
    .miss_busy      (miss_busy),
    .miss_err       (miss_err),
    .stall_cnt      (stall_cnt)
  );

  assign ctl = {pc_en, en_d, en_e, en_m, en_w,
                flush_n_d, flush_n_e,
                redirect_f, miss_busy};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s got=%0h exp=%0h",
                tag, got, exp);
  endtask

  initial begin
    total          = 0;
    passed         = 0;
    rst            = 1'b1;
    load_use_d     = 1'b0;
    branch_taken_e = 1'b0;
    icache_stall_f = 1'b0;
    dcache_req_m   = 1'b0;
    dcache_hit_m   = 1'b0;
    dcache_ready   = 1'b0;

    tick();
    tick();
    chk("rst_ctl", 16'(ctl), 16'(C_RST));
    chk("rst_cnt", 16'(stall_cnt), 16'd0);
    chk("rst_err", 16'(miss_err), 16'd0);

    rst = 1'b0;
    #1 chk("idle_ctl", 16'(ctl), 16'(C_DEF));

    load_use_d = 1'b1;
    #1 chk("lu_ctl", 16'(ctl), 16'(C_LU));
    tick();
    load_use_d = 1'b0;
    #1 chk("lu_cnt", 16'(stall_cnt), 16'd1);
    chk("lu_rel", 16'(ctl), 16'(C_DEF));

    load_use_d     = 1'b1;
    branch_taken_e = 1'b1;
    #1 chk("br_lu_ctl", 16'(ctl), 16'(C_BR));
    tick();
    load_use_d     = 1'b0;
    branch_taken_e = 1'b0;
    #1 chk("br_lu_cnt", 16'(stall_cnt), 16'd1);

    icache_stall_f = 1'b1;
    #1 chk("im_ctl", 16'(ctl), 16'(C_IM));
    tick();
    load_use_d = 1'b1;
    #1 chk("im_cnt", 16'(stall_cnt), 16'd2);
    chk("lu_im_ctl", 16'(ctl), 16'(C_LU));
    tick();
    load_use_d     = 1'b0;
    branch_taken_e = 1'b1;
    #1 chk("lu_im_cnt", 16'(stall_cnt), 16'd3);
    chk("br_im_ctl", 16'(ctl), 16'(C_BR));
    tick();
    branch_taken_e = 1'b0;
    icache_stall_f = 1'b0;
    #1 chk("br_im_cnt", 16'(stall_cnt), 16'd3);

    // D-miss: t0 detect, ready at t0+5
    dcache_req_m = 1'b1;
    dcache_hit_m = 1'b0;
    #1 chk("dm_t0", 16'(ctl), 16'(C_DMI));
    tick();
    dcache_req_m   = 1'b0;
    branch_taken_e = 1'b1;
    load_use_d     = 1'b1;
    #1 chk("dm_t1", 16'(ctl), 16'(C_DMB));
    for (int i = 2; i <= 4; i++) begin
      tick();
      #1 chk("dm_miss", 16'(ctl), 16'(C_DMB));
    end
    tick();
    dcache_ready = 1'b1;
    #1 chk("dm_t5", 16'(ctl), 16'(C_DMB));
    tick();
    dcache_ready = 1'b0;
    #1 chk("dm_replay", 16'(ctl), 16'(C_DMB));
    tick();
    #1 chk("dm_t7_br", 16'(ctl), 16'(C_BR));
    chk("dm_cnt", 16'(stall_cnt), 16'd10);
    chk("dm_err", 16'(miss_err), 16'd1);
    branch_taken_e = 1'b0;
    load_use_d     = 1'b0;

    dcache_req_m = 1'b1;
    dcache_hit_m = 1'b1;
    #1 chk("hit_ctl", 16'(ctl), 16'(C_DEF));
    tick();
    dcache_req_m = 1'b0;
    dcache_hit_m = 1'b0;
    #1 chk("hit_after", 16'(ctl), 16'(C_DEF));
    chk("hit_cnt", 16'(stall_cnt), 16'd10);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1 chk("rst2_err", 16'(miss_err), 16'd0);
    chk("rst2_cnt", 16'(stall_cnt), 16'd0);

    // Timeout with ready in the entry cycle
    dcache_req_m = 1'b1;
    dcache_ready = 1'b1;
    #1 chk("to_t0", 16'(ctl), 16'(C_DMI));
    tick();
    dcache_req_m = 1'b0;
    dcache_ready = 1'b0;
    #1 chk("to_c1", 16'(ctl), 16'(C_DMB));
    chk("to_err_c1", 16'(miss_err), 16'd0);
    for (int i = 2; i <= 4; i++) begin
      tick();
      #1 chk("to_busy", 16'(ctl), 16'(C_DMB));
      chk("to_err_lo", 16'(miss_err), 16'd0);
    end
    tick();
    #1 chk("to_err_set", 16'(miss_err), 16'd1);
    chk("to_c5", 16'(ctl), 16'(C_DMB));
    repeat (12) tick();
    #1 chk("cnt_sat", 16'(stall_cnt), 16'd15);
    chk("err_sticky", 16'(miss_err), 16'd1);

    rst = 1'b1;
    #1 chk("rst_in_miss", 16'(ctl), 16'(C_RST));
    tick();
    chk("rst_hold", 16'(ctl), 16'(C_RST));
    rst = 1'b0;
    #1 chk("rel_ctl", 16'(ctl), 16'(C_DEF));
    chk("rel_cnt", 16'(stall_cnt), 16'd0);
    chk("rel_err", 16'(miss_err), 16'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
